// File: rtl/dff_pkg.sv
// Shared constants and width helpers for the dff_pipe register pipeline.
package dff_pkg;

    localparam int BIT_WIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int LANES_DEF     = 2;

    function automatic int lane_vec_w(input int lanes, input int bit_width);
        return lanes * bit_width;
    endfunction

    // Counter must represent 0..DEPTH inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: valid bit plus data word, async reset, sync clear, enable.
module dff_stage
    import dff_pkg::*;
#(
    parameter int W = lane_vec_w(LANES_DEF, BIT_WIDTH_DEF)
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         clr,
    input  logic         en,
    input  logic         v_in,
    input  logic [W-1:0] d_in,
    output logic         v_out,
    output logic [W-1:0] q_output
);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            v_out    <= 1'b0;
            q_output <= '0;
        end else if (clr) begin
            v_out    <= 1'b0;
            q_output <= '0;
        end else if (en) begin
            v_out    <= v_in;
            // Bubbles always carry zero data.
            q_output <= v_in ? d_in : '0;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, LANES-wide lock-step delay line with valid tagging, stall,
// backpressure, synchronous flush and occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int LANES     = LANES_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst_in,
    input  logic                                     en,
    input  logic                                     flush,
    input  logic                                     valid_in,
    input  logic [lane_vec_w(LANES, BIT_WIDTH)-1:0]  d_in,
    input  logic                                     ready_in,
    output logic                                     ready_out,
    output logic                                     valid_out,
    output logic [lane_vec_w(LANES, BIT_WIDTH)-1:0]  q_output,
    output logic [occ_w(DEPTH)-1:0]                  occupancy
);

    localparam int VEC_W = lane_vec_w(LANES, BIT_WIDTH);
    localparam int OCC_W = occ_w(DEPTH);

    logic             advance;
    logic [DEPTH:0]   v_chain;
    logic [VEC_W-1:0] d_chain [DEPTH+1];

    // The whole pipe moves together; a held output freezes bubbles too.
    assign advance   = en & (~valid_out | ready_in);
    assign ready_out = advance & ~flush & ~rst_in;

    assign v_chain[0] = valid_in;
    assign d_chain[0] = d_in;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dff_stage #(
            .W(VEC_W)
        ) u_stage (
            .clk      (clk),
            .rst_in   (rst_in),
            .clr      (flush),
            .en       (advance),
            .v_in     (v_chain[k]),
            .d_in     (d_chain[k]),
            .v_out    (v_chain[k+1]),
            .q_output (d_chain[k+1])
        );
    end

    assign valid_out = v_chain[DEPTH];
    assign q_output  = d_chain[DEPTH];

    logic occ_inc;
    logic occ_dec;

    assign occ_inc = advance & valid_in;
    assign occ_dec = advance & valid_out;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            case ({occ_inc, occ_dec})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: items are tagged with the advance count at
// acceptance and must surface after exactly DEPTH advancing edges.
module tb_dff_pipe;

    localparam int BIT_WIDTH = 8;
    localparam int DEPTH     = 4;
    localparam int LANES     = 2;
    localparam int VW        = LANES * BIT_WIDTH;
    localparam int OW        = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          valid_in = 1'b0;
    logic [VW-1:0] d_in = '0;
    logic          ready_in = 1'b0;
    logic          ready_out;
    logic          valid_out;
    logic [VW-1:0] q_output;
    logic [OW-1:0] occupancy;

    dff_pipe #(
        .BIT_WIDTH(BIT_WIDTH),
        .DEPTH    (DEPTH),
        .LANES    (LANES)
    ) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .en        (en),
        .flush     (flush),
        .valid_in  (valid_in),
        .d_in      (d_in),
        .ready_in  (ready_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .q_output  (q_output),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] data;
        int            tag;
    } item_t;

    item_t sb[$];
    int    adv_cnt = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Head item is at the last stage once DEPTH-1 further advances have occurred.
    function automatic logic model_valid();
        return (sb.size() > 0) && (adv_cnt - sb[0].tag == DEPTH - 1);
    endfunction

    // Scoreboard: pop on DUT handshake, then apply this edge's push/flush.
    always @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            sb.delete();
        end else begin
            logic  mv;
            item_t e;
            mv = model_valid();
            if (valid_out && ready_in && en && !flush) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", {47'd0, valid_out}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(q_output), 64'(e.data));
                    check("latency", 64'(adv_cnt - e.tag + 1), 64'(DEPTH));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (en && (!mv || ready_in)) begin
                adv_cnt++;
                if (valid_in) sb.push_back('{data: d_in, tag: adv_cnt});
            end
        end
    end

    // Output monitor away from the active edge.
    always @(negedge clk) begin
        logic          ev;
        logic [VW-1:0] eq;
        logic          er;
        ev = model_valid();
        eq = ev ? sb[0].data : '0;
        er = !rst_in && en && (!ev || ready_in) && !flush;
        check("valid_out", 64'(valid_out), 64'(ev));
        check("q_output", 64'(q_output), 64'(eq));
        check("occupancy", 64'(occupancy), 64'(sb.size()));
        check("ready_out", 64'(ready_out), 64'(er));
    end

    task automatic cyc(input logic e, input logic f, input logic v,
                       input logic [VW-1:0] d, input logic r);
        en = e; flush = f; valid_in = v; d_in = d; ready_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(valid_out), 64'd0);
        check("reset_occ", 64'(occupancy), 64'd0);
        rst_in = 1'b0;

        // streaming
        cyc(1, 0, 1, 16'h0257, 1);
        cyc(1, 0, 1, 16'h1044, 1);
        cyc(1, 0, 1, 16'hFF01, 1);
        idle(6);

        // backpressure
        cyc(1, 0, 1, 16'h1111, 1);
        cyc(1, 0, 1, 16'h2222, 1);
        cyc(1, 0, 1, 16'h3333, 1);
        cyc(1, 0, 1, 16'h4444, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 16'hDEAD, 0);
        idle(6);

        // bubbles
        cyc(1, 0, 1, 16'hA1A1, 1);
        cyc(1, 0, 0, 16'h5A5A, 1);
        cyc(1, 0, 1, 16'hB2B2, 1);
        idle(6);

        // flush with simultaneous valid_in
        cyc(1, 0, 1, 16'h0101, 1);
        cyc(1, 0, 1, 16'h0202, 1);
        cyc(1, 0, 1, 16'h0303, 1);
        cyc(1, 1, 1, 16'hBBAA, 1);
        idle(6);

        // enable low mid-stream
        cyc(1, 0, 1, 16'h0C0C, 1);
        cyc(1, 0, 1, 16'h0D0D, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'hEEEE, 1);
        cyc(1, 0, 1, 16'h0E0E, 1);
        cyc(1, 0, 1, 16'h0F0F, 1);
        idle(6);

        // async reset between edges
        cyc(1, 0, 1, 16'h7777, 1);
        cyc(1, 0, 1, 16'h8888, 1);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid_out), 64'd0);
        check("async_rst_q", 64'(q_output), 64'd0);
        check("async_rst_occ", 64'(occupancy), 64'd0);
        check("async_rst_ready", 64'(ready_out), 64'd0);
        @(posedge clk);
        #1 rst_in = 1'b0;
        cyc(1, 0, 1, 16'h9999, 1);
        idle(6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 30) == 0, ($urandom % 4) != 0,
                VW'($urandom), ($urandom % 3) != 0);
        end

        idle(DEPTH + 2);
        check("drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
